// File: rtl/datapath_arbiter.sv
// datapath_arbiter: two-requester arbiter in front of a single-cycle datapath (macro DATAPATH_ARB_RR_EN selects round-robin)
module datapath_arbiter #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic                req1_valid,
  output logic                req0_ready,
  output logic                req1_ready,
  input  logic signed [N-1:0] req0_a,
  input  logic signed [N-1:0] req0_b,
  input  logic signed [N-1:0] req1_a,
  input  logic signed [N-1:0] req1_b,
  input  logic        [2:0]   req0_op,
  input  logic        [2:0]   req1_op,
  output logic        [N-1:0] dp_a,
  output logic        [N-1:0] dp_b,
  output logic        [2:0]   dp_opcode,
  input  logic        [N-1:0] dp_y,
  input  logic                dp_co,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic        [N-1:0] rsp_y,
  output logic                rsp_co,
  output logic                rsp_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t       state_q, state_d;
  logic [N-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d, rsp_y_q, rsp_y_d;
  logic [2:0]   dp_op_q, dp_op_d;
  logic         rsp_co_q, rsp_co_d, rsp_id_q, rsp_id_d;
  logic         grant, accept;
`ifdef DATAPATH_ARB_RR_EN
  logic         last_grant_q, last_grant_d;
  // on contention favour whoever did not win last; otherwise the lone requester
  always_comb grant = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
`else
  // requester 0 wins whenever it is asking
  always_comb grant = ~req0_valid;
`endif
  assign req0_ready = !rst && state_q == IDLE && req0_valid && !grant;
  assign req1_ready = !rst && state_q == IDLE && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_opcode  = dp_op_q;
  assign rsp_valid  = state_q == RESP;
  assign rsp_y      = rsp_y_q;
  assign rsp_co     = rsp_co_q;
  assign rsp_id     = rsp_id_q;
  // next state: latch operands on accept, capture result after one EXEC cycle, hold until handshake
  always_comb begin
    state_d  = state_q;
    dp_a_d   = dp_a_q;
    dp_b_d   = dp_b_q;
    dp_op_d  = dp_op_q;
    rsp_y_d  = rsp_y_q;
    rsp_co_d = rsp_co_q;
    rsp_id_d = rsp_id_q;
`ifdef DATAPATH_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d  = EXEC;
        dp_a_d   = grant ? req1_a : req0_a;
        dp_b_d   = grant ? req1_b : req0_b;
        dp_op_d  = grant ? req1_op : req0_op;
        rsp_id_d = grant;
`ifdef DATAPATH_ARB_RR_EN
        last_grant_d = grant;
`endif
      end
      EXEC: begin
        state_d  = RESP;
        rsp_y_d  = dp_y;
        rsp_co_d = dp_co;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dp_a_q   <= '0;
      dp_b_q   <= '0;
      dp_op_q  <= '0;
      rsp_y_q  <= '0;
      rsp_co_q <= 1'b0;
      rsp_id_q <= 1'b0;
`ifdef DATAPATH_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      dp_a_q   <= dp_a_d;
      dp_b_q   <= dp_b_d;
      dp_op_q  <= dp_op_d;
      rsp_y_q  <= rsp_y_d;
      rsp_co_q <= rsp_co_d;
      rsp_id_q <= rsp_id_d;
`ifdef DATAPATH_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end
endmodule

// File: tb/tb_datapath_arbiter.sv
// tb_datapath_arbiter: directed self-checking bench for datapath_arbiter
module tb_datapath_arbiter;
  localparam int N = 16;
  logic clk = 1'b0, rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic signed [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op, dp_opcode;
  logic [N-1:0] dp_a, dp_b, dp_y, rsp_y;
  logic dp_co, rsp_valid, rsp_ready, rsp_co, rsp_id;
  logic [N:0] dp_sum;
  int checks = 0, failures = 0, n;
  logic exp_id [4];
  logic got_id [4];
  always #5 clk = ~clk;
  assign dp_sum = dp_opcode == 3'd1 ? {1'b0, dp_a} - {1'b0, dp_b} : {1'b0, dp_a} + {1'b0, dp_b};
  assign dp_y   = dp_sum[N-1:0];
  assign dp_co  = dp_sum[N];
  datapath_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .dp_a(dp_a), .dp_b(dp_b), .dp_opcode(dp_opcode),
    .dp_y(dp_y), .dp_co(dp_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_co(rsp_co), .rsp_id(rsp_id)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
`ifdef DATAPATH_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    #3;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_rsp_id", rsp_id, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 5; req0_b = 3; req0_op = 3'd0; rsp_ready = 1'b1;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("single_dp_a", dp_a, 5);
    chk("single_dp_b", dp_b, 3);
    chk("single_exec_valid", rsp_valid, 0);
    tick();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_y", rsp_y, 8);
    chk("single_rsp_co", rsp_co, 0);
    chk("single_rsp_id", rsp_id, 0);
    tick();
    chk("single_done", rsp_valid, 0);
    req1_valid = 1'b1;
    #1;
    chk("single_idle_ready1", req1_ready, 1);
    req1_valid = 1'b0;
    do_reset();
    req0_a = 1; req0_b = 2; req1_a = 10; req1_b = 20;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (rsp_valid) begin
        got_id[n] = rsp_id;
        chk("cont_rsp_y", rsp_y, rsp_id ? 30 : 3);
        n++;
        if (n == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    chk("cont_count", n, 4);
    for (int i = 0; i < n; i++) chk($sformatf("cont_id%0d", i), got_id[i], exp_id[i]);
    tick();
    chk("cont_idle", rsp_valid, 0);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 100; req0_b = 23; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 1; req1_b = 1;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_y", rsp_y, 123);
      chk("bp_ready1", req1_ready, 0);
      tick();
    end
    chk("bp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    chk("bp_handshake", rsp_valid, 0);
    chk("bp_idle_ready1", req1_ready, 1);
    req1_valid = 1'b0;
    tick();
    chk("bp_single", rsp_valid, 0);
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 1; req1_op = 3'd0;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("carry_valid", rsp_valid, 1);
    chk("carry_y", rsp_y, 0);
    chk("carry_co", rsp_co, 1);
    chk("carry_id", rsp_id, 1);
    tick();
    req0_valid = 1'b1; req0_a = 7; req0_b = 1; req0_op = 3'd0;
    tick();
    req0_valid = 1'b0; req0_a = 99;
    chk("cap_dp_a", dp_a, 7);
    tick();
    chk("cap_rsp_y", rsp_y, 8);
    tick();
    req0_valid = 1'b1; req0_a = 2; req0_b = 2;
    tick();
    req0_valid = 1'b0;
    chk("mid_dp_a", dp_a, 2);
    rst = 1'b1;
    #1;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_dp_a_rst", dp_a, 0);
    chk("mid_rsp_y", rsp_y, 0);
    chk("mid_rsp_co", rsp_co, 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_rsp", rsp_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
